// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution pixel path: pixel width, default
// image width and the padding FSM state type.
package conv_pkg;

    localparam int PIXEL_DATAW = 8;
    localparam int IMAGE_WIDTH = 512;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        TOP   = 3'd1,
        LEFT  = 3'd2,
        BODY  = 3'd3,
        RIGHT = 3'd4,
        BOT   = 3'd5
    } pad_state_t;

    // True for the states that emit zero beats without waiting on upstream.
    function automatic logic is_pad_state(input pad_state_t s);
        return (s == TOP) || (s == LEFT) || (s == RIGHT) || (s == BOT);
    endfunction

endpackage

// File: rtl/conv_pad_out_stage.sv
// Single-entry output slot for the padded pixel stream. The slot is free when
// it is empty or its current beat is being taken downstream this cycle, so a
// new beat can be loaded back-to-back with no bubble.
module conv_pad_out_stage #(
    parameter int PIXEL_DATAW = conv_pkg::PIXEL_DATAW
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [PIXEL_DATAW-1:0] load_x,
    input  logic                   load_last,
    input  logic                   i_ready,
    output logic                   slot_free,
    output logic                   o_valid,
    output logic [PIXEL_DATAW-1:0] o_x,
    output logic                   o_last
);

    assign slot_free = !o_valid || i_ready;

    // Load a new beat when the slot frees up, drain to empty otherwise, and
    // hold everything stable while downstream stalls a pending beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_valid <= 1'b0;
            o_x     <= '0;
            o_last  <= 1'b0;
        end else if (slot_free) begin
            o_valid <= load;
            if (load) begin
                o_x    <= load_x;
                o_last <= load_last;
            end else begin
                o_last <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/conv_pad_streamer.sv
// Zero-pads a raw IMAGE_WIDTH x IMAGE_HEIGHT pixel stream into an
// (IMAGE_WIDTH+2) x (IMAGE_HEIGHT+2) frame for the 3x3 convolution engine.
// The FSM walks top pad row, then LEFT/BODY/RIGHT per image row, then the
// bottom pad row; pad beats never wait on upstream, body beats only move on
// an upstream transfer.
module conv_pad_streamer #(
    parameter int IMAGE_WIDTH  = conv_pkg::IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = 512,
    parameter int PIXEL_DATAW  = conv_pkg::PIXEL_DATAW
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_valid,
    input  logic [PIXEL_DATAW-1:0] i_x,
    output logic                   o_ready,
    output logic                   o_valid,
    output logic [PIXEL_DATAW-1:0] o_x,
    output logic                   o_last,
    input  logic                   i_ready
);
    import conv_pkg::*;

    localparam int COL_W = $clog2(IMAGE_WIDTH + 2);
    localparam int ROW_W = $clog2(IMAGE_HEIGHT + 1);

    // Final column index of a full padded row and of an unpadded body row.
    localparam logic [COL_W-1:0] PAD_END  = COL_W'(IMAGE_WIDTH + 1);
    localparam logic [COL_W-1:0] BODY_END = COL_W'(IMAGE_WIDTH - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMAGE_HEIGHT);

    pad_state_t             state;
    pad_state_t             next_state;
    logic [COL_W-1:0]       col;
    logic [ROW_W-1:0]       row;
    logic                   state_done;
    logic                   slot_free;
    logic                   load;
    logic [PIXEL_DATAW-1:0] load_x;
    logic                   load_last;

    // Decide whether the beat loaded this cycle closes the current state and
    // which state follows it.
    always_comb begin
        state_done = 1'b0;
        next_state = state;
        case (state)
            IDLE: begin
                state_done = 1'b0;
                next_state = TOP;
            end
            TOP: begin
                state_done = (col == PAD_END);
                next_state = LEFT;
            end
            LEFT: begin
                state_done = 1'b1;
                next_state = BODY;
            end
            BODY: begin
                state_done = (col == BODY_END);
                next_state = RIGHT;
            end
            RIGHT: begin
                state_done = 1'b1;
                next_state = (row == LAST_ROW) ? BOT : LEFT;
            end
            BOT: begin
                state_done = (col == PAD_END);
                next_state = IDLE;
            end
            default: begin
                state_done = 1'b1;
                next_state = IDLE;
            end
        endcase
    end

    // Build the beat offered to the output slot and the upstream handshake.
    always_comb begin
        load      = slot_free && (is_pad_state(state) || ((state == BODY) && i_valid));
        load_x    = (state == BODY) ? i_x : '0;
        load_last = (state == BOT) && (col == PAD_END);
        o_ready   = (state == BODY) && slot_free;
    end

    // Padding FSM with beat and row counters; everything advances only when a
    // beat is loaded, so a downstream stall or upstream bubble freezes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            col   <= '0;
            row   <= '0;
        end else if (state == IDLE) begin
            col <= '0;
            row <= '0;
            // Wait for the previous frame's last beat to drain before restarting.
            if (i_valid && !o_valid) begin
                state <= TOP;
            end
        end else if (load) begin
            if (state_done) begin
                state <= next_state;
                col   <= '0;
                if (state == BODY) begin
                    row <= row + 1'b1;
                end
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    conv_pad_out_stage #(
        .PIXEL_DATAW(PIXEL_DATAW)
    ) u_out_stage (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_x    (load_x),
        .load_last (load_last),
        .i_ready   (i_ready),
        .slot_free (slot_free),
        .o_valid   (o_valid),
        .o_x       (o_x),
        .o_last    (o_last)
    );

endmodule

// File: tb/tb_conv_pad_streamer.sv
// Bench for conv_pad_streamer: a 4x2 instance for the directed frame tests and
// a 16x12 instance for a randomised stream with random downstream ready.
module tb_conv_pad_streamer;

    localparam int W      = 4;
    localparam int H      = 2;
    localparam int FRAME  = (W + 2) * (H + 2);
    localparam int BW     = 16;
    localparam int BH     = 12;
    localparam int BFRAME = (BW + 2) * (BH + 2);

    typedef struct {
        logic       is_body;
        logic [7:0] in_x;
        logic [7:0] exp_x;
        logic       exp_last;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       a_i_valid, a_o_ready, a_o_valid, a_o_last, a_i_ready;
    logic [7:0] a_i_x, a_o_x;
    logic       b_i_valid, b_o_ready, b_o_valid, b_o_last, b_i_ready;
    logic [7:0] b_i_x, b_o_x;

    conv_pad_streamer #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .PIXEL_DATAW(8)) dut_a (
        .clk(clk), .reset(reset), .i_valid(a_i_valid), .i_x(a_i_x), .o_ready(a_o_ready),
        .o_valid(a_o_valid), .o_x(a_o_x), .o_last(a_o_last), .i_ready(a_i_ready));

    conv_pad_streamer #(.IMAGE_WIDTH(BW), .IMAGE_HEIGHT(BH), .PIXEL_DATAW(8)) dut_b (
        .clk(clk), .reset(reset), .i_valid(b_i_valid), .i_x(b_i_x), .o_ready(b_o_ready),
        .o_valid(b_o_valid), .o_x(b_o_x), .o_last(b_o_last), .i_ready(b_i_ready));

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    vec_t       tbl [FRAME];
    logic [7:0] px [$];
    logic [7:0] cap_x [$];
    logic       cap_last [$];
    int         cap_cyc [$];
    int         b_cap [$];
    bit         abort = 1'b0;
    int         stall_at = -1;
    int         stall_left = 0;
    bit         b_rand = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every downstream transfer of each DUT.
    always @(negedge clk) begin
        if (!reset && a_o_valid && a_i_ready) begin
            cap_x.push_back(a_o_x);
            cap_last.push_back(a_o_last);
            cap_cyc.push_back(cyc);
        end
        if (!reset && b_o_valid && b_i_ready) begin
            b_cap.push_back({23'd0, b_o_last, b_o_x});
        end
    end

    // Downstream ready for dut_a: high except for a programmed stall window.
    initial begin
        a_i_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_left > 0 && cap_x.size() == stall_at) begin
                a_i_ready = 1'b0;
                stall_left--;
            end else begin
                a_i_ready = 1'b1;
            end
        end
    end

    // Downstream ready for dut_b: random while the smoke test runs.
    initial begin
        b_i_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            b_i_ready = b_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no end, required summary");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic int count_lasts();
        int n = 0;
        foreach (cap_last[i]) n += int'(cap_last[i]);
        return n;
    endfunction

    function automatic int count_b_lasts();
        int n = 0;
        foreach (b_cap[i]) n += (b_cap[i] >> 8) & 1;
        return n;
    endfunction

    task automatic clear_capture();
        cap_x.delete();
        cap_last.delete();
        cap_cyc.delete();
    endtask

    // Feed the body pixels of the table (plus offset) into dut_a; optional
    // bubble of bub_len idle cycles after pixel number bub_after.
    task automatic drive_a(input int offset, input int bub_after, input int bub_len, output bit ok);
        bit acc;
        int t;
        ok = 1'b1;
        for (int k = 0; k < px.size(); k++) begin
            a_i_valid = 1'b1;
            a_i_x     = px[k] + 8'(offset);
            acc = 1'b0;
            t   = 0;
            while (!acc) begin
                @(negedge clk);
                if (abort) begin
                    a_i_valid = 1'b0;
                    return;
                end
                acc = a_o_ready;
                @(posedge clk);
                #1;
                t++;
                if (t > 500) begin
                    ok = 1'b0;
                    a_i_valid = 1'b0;
                    return;
                end
            end
            if (k + 1 == bub_after) begin
                a_i_valid = 1'b0;
                repeat (bub_len) @(posedge clk);
                #1;
            end
        end
        a_i_valid = 1'b0;
    endtask

    task automatic wait_lasts(input int n);
        int t = 0;
        while (count_lasts() < n && t < 1000) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("o_last_count", count_lasts(), n);
    endtask

    task automatic compare_frame(input string name, input int base, input int offset);
        int act;
        int exp;
        for (int i = 0; i < FRAME; i++) begin
            act = (base + i < cap_x.size()) ?
                  {23'd0, cap_last[base + i], cap_x[base + i]} : 32'h1ff;
            exp = {23'd0, tbl[i].exp_last, tbl[i].is_body ? tbl[i].exp_x + 8'(offset) : tbl[i].exp_x};
            check($sformatf("%s_beat%0d", name, base + i), act, exp);
        end
    endtask

    initial begin
        logic [7:0] exp_rows [FRAME];
        bit ok;
        int t;
        int start_cyc;
        bit acc;
        bit timed_out;
        logic [7:0] bpx [BW*BH];
        int bexp [$];

        exp_rows = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0,
                     8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd0,
                     8'd0, 8'd5, 8'd6, 8'd7, 8'd8, 8'd0,
                     8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        for (int i = 0; i < FRAME; i++) begin
            tbl[i].is_body  = (exp_rows[i] != 8'd0);
            tbl[i].in_x     = exp_rows[i];
            tbl[i].exp_x    = exp_rows[i];
            tbl[i].exp_last = (i == FRAME - 1);
            if (tbl[i].is_body) px.push_back(tbl[i].in_x);
        end

        reset = 1'b1;
        a_i_valid = 1'b0; a_i_x = '0;
        b_i_valid = 1'b0; b_i_x = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_o_valid", int'(a_o_valid), 0);
        check("reset_o_x", int'(a_o_x), 0);
        check("reset_o_last", int'(a_o_last), 0);
        check("reset_o_ready", int'(a_o_ready), 0);
        @(posedge clk);
        #1;

        // Basic frame.
        clear_capture();
        start_cyc = cyc;
        drive_a(0, 0, 0, ok);
        check("basic_drive_ok", int'(ok), 1);
        wait_lasts(1);
        check("basic_beats", cap_x.size(), FRAME);
        check("basic_first_latency", (cap_cyc.size() > 0) ? cap_cyc[0] - start_cyc : -1, 2);
        compare_frame("basic", 0, 0);

        // Downstream stall on beat 9.
        clear_capture();
        stall_at = 8;
        stall_left = 3;
        fork
            begin
                drive_a(0, 0, 0, ok);
                check("stall_drive_ok", int'(ok), 1);
            end
            begin
                for (int j = 0; j < 3; j++) begin
                    t = 0;
                    @(negedge clk);
                    while (a_i_ready && t < 200) begin
                        @(negedge clk);
                        t++;
                    end
                    check($sformatf("stall%0d_o_valid", j), int'(a_o_valid), 1);
                    check($sformatf("stall%0d_o_x", j), int'(a_o_x), 2);
                    check($sformatf("stall%0d_o_ready", j), int'(a_o_ready), 0);
                end
            end
        join
        wait_lasts(1);
        check("stall_beats", cap_x.size(), FRAME);
        compare_frame("stall", 0, 0);
        stall_at = -1;

        // Upstream bubble between pixels 6 and 7.
        clear_capture();
        drive_a(0, 6, 4, ok);
        check("bubble_drive_ok", int'(ok), 1);
        wait_lasts(1);
        check("bubble_beats", cap_x.size(), FRAME);
        compare_frame("bubble", 0, 0);

        // Back-to-back frames: pixels 1..8 then 9..16.
        clear_capture();
        drive_a(0, 0, 0, ok);
        drive_a(8, 0, 0, ok);
        check("b2b_drive_ok", int'(ok), 1);
        wait_lasts(2);
        check("b2b_beats", cap_x.size(), 2 * FRAME);
        compare_frame("b2b_f1", 0, 0);
        compare_frame("b2b_f2", FRAME, 8);
        check("b2b_second_first_pixel", (cap_x.size() > FRAME + 7) ? int'(cap_x[FRAME + 7]) : -1, 9);
        check("b2b_idle_gap_ge3",
              (cap_cyc.size() > FRAME) ? int'(cap_cyc[FRAME] - cap_cyc[FRAME - 1] >= 3) : 0, 1);

        // Reset asserted for one cycle while pixel 3 is offered.
        clear_capture();
        abort = 1'b0;
        fork
            drive_a(0, 0, 0, ok);
            begin
                t = 0;
                @(negedge clk);
                while (!(a_i_valid && a_i_x == 8'd3) && t < 500) begin
                    @(negedge clk);
                    t++;
                end
                check("rst_pixel3_offered", int'(a_i_valid && a_i_x == 8'd3), 1);
                #2;
                reset = 1'b1;
                abort = 1'b1;
                @(posedge clk);
                #1;
                reset = 1'b0;
                @(negedge clk);
                check("rst_o_valid", int'(a_o_valid), 0);
                check("rst_o_ready", int'(a_o_ready), 0);
                check("rst_o_x", int'(a_o_x), 0);
                check("rst_o_last", int'(a_o_last), 0);
            end
        join
        a_i_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rst_partial_lasts", count_lasts(), 0);
        clear_capture();
        abort = 1'b0;
        drive_a(0, 0, 0, ok);
        check("rst_drive_ok", int'(ok), 1);
        wait_lasts(1);
        check("rst_beats", cap_x.size(), FRAME);
        compare_frame("rst", 0, 0);

        // Randomised frame on the 16x12 instance with random ready and bubbles.
        for (int k = 0; k < BW * BH; k++) bpx[k] = 8'($urandom_range(0, 255));
        for (int r = 0; r < BH + 2; r++) begin
            for (int c = 0; c < BW + 2; c++) begin
                if (r >= 1 && r <= BH && c >= 1 && c <= BW)
                    bexp.push_back({24'd0, bpx[(r - 1) * BW + c - 1]});
                else
                    bexp.push_back((r == BH + 1 && c == BW + 1) ? 32'h100 : 32'h0);
            end
        end
        b_cap.delete();
        b_rand = 1'b1;
        timed_out = 1'b0;
        for (int k = 0; k < BW * BH && !timed_out; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                b_i_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            b_i_valid = 1'b1;
            b_i_x = bpx[k];
            acc = 1'b0;
            t = 0;
            while (!acc && t < 2000) begin
                @(negedge clk);
                acc = b_o_ready;
                @(posedge clk);
                #1;
                t++;
            end
            if (!acc) timed_out = 1'b1;
        end
        b_i_valid = 1'b0;
        check("smoke_drive_ok", int'(!timed_out), 1);
        t = 0;
        while (count_b_lasts() == 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        repeat (4) @(posedge clk);
        #1;
        b_rand = 1'b0;
        check("smoke_beats", b_cap.size(), BFRAME);
        check("smoke_lasts", count_b_lasts(), 1);
        for (int i = 0; i < BFRAME; i++) begin
            check($sformatf("smoke_beat%0d", i), (i < b_cap.size()) ? b_cap[i] : -1, bexp[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_pad_streamer.md
# conv_pad_streamer

Transmit-side feeder for the 3x3 convolution engine's pixel input. Accepts a raw, unpadded grayscale image stream (IMAGE_WIDTH pixels per row, IMAGE_HEIGHT rows) from an upstream source. Re-emits it as a zero-padded (IMAGE_WIDTH+2) x (IMAGE_HEIGHT+2) stream on the same valid/ready protocol the convolution block consumes. Sits directly in front of the convolution block, so upstream producers never need to generate padding themselves.

## Interface
- IMAGE_WIDTH, 512, unpadded pixels per row
- IMAGE_HEIGHT, 512, unpadded rows per frame (>=1)
- PIXEL_DATAW, 8, pixel width in bits
- clk  in  1  clock, all logic rising-edge
- reset  in  1  reset, synchronous, active-high
- i_valid  in  1  upstream pixel valid
- i_x  in  PIXEL_DATAW  upstream pixel, unsigned
- o_ready  out  1  this block accepts an upstream pixel this cycle
- o_valid  out  1  padded output beat valid
- o_x  out  PIXEL_DATAW  padded output pixel
- o_last  out  1  marks final beat of a padded frame
- i_ready  in  1  downstream (convolution) ready

## Operation
- Transfer rule, both sides: a beat moves on a cycle where valid & ready are both 1.
- Output slot: o_valid/o_x/o_last are registers. Slot is free when !o_valid || i_ready.
- o_ready = (state==BODY) && slot free. Combinational from i_ready and state.
- States and transitions:
  - IDLE: emits nothing, o_ready=0. Moves to TOP when i_valid=1. That pixel is not consumed.
  - TOP: emits IMAGE_WIDTH+2 zero beats, then goes to LEFT.
  - LEFT: emits 1 zero beat, then goes to BODY.
  - BODY: passes IMAGE_WIDTH upstream pixels unchanged, then goes to RIGHT.
  - RIGHT: emits 1 zero beat. Goes to LEFT if rows remain, else BOT.
  - BOT: emits IMAGE_WIDTH+2 zero beats, with o_last=1 on the final one, then goes to IDLE.
- Pad beats are loaded whenever the slot is free, with no upstream dependency.
- In BODY, a beat is loaded only on an upstream transfer.
- Counters:
  - col: $clog2(IMAGE_WIDTH+2) bits, counts beats in the current state. Clears on every state change.
  - row: $clog2(IMAGE_HEIGHT+1) bits, counts completed body rows. Clears in IDLE.
- No arithmetic on pixel data; o_x = i_x bit-exact, or 0 for pad beats.

## Timing
- Reset values: o_valid=0, o_x=0, o_last=0, o_ready=0. State=IDLE, counters=0.
- Latency: an accepted upstream pixel appears on o_x in the next cycle.
- First top-pad beat is valid 2 cycles after i_valid first rises in IDLE.
- Throughput: 1 beat/cycle when i_ready=1 and upstream keeps i_valid high in BODY.
- Frame length: (IMAGE_WIDTH+2)*(IMAGE_HEIGHT+2) beats, exactly one o_last.
- Downstream stall (o_valid=1, i_ready=0):
  - o_x, o_valid and o_last hold stable.
  - o_ready=0.
  - State and counters freeze.
- Upstream bubble in BODY (i_valid=0):
  - o_valid deasserts after the pending beat transfers.
  - col holds.
  - No pad beat is ever inserted mid-row.
- Simultaneous downstream take and upstream give on one cycle: slot reloads with no bubble.
- Row wrap: RIGHT of the last row goes straight to BOT. No extra LEFT/RIGHT pair is emitted.
- Frame-to-frame: after the o_last transfer, IDLE holds for at least 1 cycle before the next TOP.
- Reset mid-frame: all registers return to reset values next cycle. The partial frame is discarded, no o_last is emitted, and the next frame restarts at TOP.

## Structure
- Shared package conv_pkg holds:
  - PIXEL_DATAW and IMAGE_WIDTH constants, shared with the convolution block.
  - pad_state_t enum {IDLE, TOP, LEFT, BODY, RIGHT, BOT}.
- One sub-module, conv_pad_out_stage: the output slot register. It carries load/hold/free logic, and o_valid/o_x/o_last come from it.
- FSM and counters live in conv_pad_streamer.

## Test plan
- Basic frame: IMAGE_WIDTH=4, IMAGE_HEIGHT=2; stream pixels 1..8 with i_ready=1. Required output, row by row:
  - 0,0,0,0,0,0
  - 0,1,2,3,4,0
  - 0,5,6,7,8,0
  - 0,0,0,0,0,0
  - 24 beats total; o_last only on beat 24; first beat 2 cycles after i_valid.
- Downstream stall: same frame with i_ready=0 for 3 cycles at beat 9 (pixel 2). o_x stays 2 with o_valid=1 for all 3 cycles, o_ready=0 throughout, and the sequence is otherwise unchanged.
- Upstream bubble: i_valid=0 for 4 cycles between pixels 6 and 7. No extra zero beats appear, and the output order is identical to the basic frame.
- Back-to-back frames: two frames, pixels 1..8 then 9..16. Required:
  - 48 beats total.
  - Exactly two o_last pulses.
  - Second frame's first body pixel is 9.
- Reset mid-frame: assert reset during pixel 3 for 1 cycle. Required:
  - Next cycle o_valid=0 and o_ready=0.
  - A new frame of pixels 1..8 then reproduces the basic frame exactly.
- Full-size smoke test: 512x512 random pixels with random i_ready. Required:
  - 514*514 beats.
  - Body beats match the input bit-exact.
  - All pad beats are 0.
